// File: rtl/pll_reset_sequencer.sv
// rtl/pll_reset_sequencer.sv - PLL lock qualified reset release sequencer
module pll_reset_sequencer #(
    parameter int STABLE_CYCLES = 1024,
    parameter int HOLD_CYCLES   = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       pll_lock,
    input  logic       soft_rst_req,
    output logic       rst_out,
    output logic       rst_n_out,
    output logic       ready,
    output logic       lock_lost,
    output logic [7:0] lock_lost_cnt
);

    localparam int MAX_CYCLES = (STABLE_CYCLES > HOLD_CYCLES) ? STABLE_CYCLES : HOLD_CYCLES;
    localparam int CW         = $clog2(MAX_CYCLES + 1);

    localparam logic [CW-1:0] STABLE_LAST = CW'(STABLE_CYCLES - 1);
    localparam logic [CW-1:0] HOLD_LAST   = CW'(HOLD_CYCLES - 1);

    typedef enum logic [1:0] {
        ST_WAIT      = 2'd0,
        ST_STABILIZE = 2'd1,
        ST_RELEASE   = 2'd2,
        ST_RUN       = 2'd3
    } state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          sync1_q, sync2_q;
    logic          rst_out_q, rst_out_d;
    logic          rst_n_out_q;
    logic          ready_q, ready_d;
    logic          lock_lost_q, lock_lost_d;
    logic [7:0]    lost_cnt_q, lost_cnt_d;
    logic          lock_s;
    logic          released;

    assign lock_s   = sync2_q;
    assign released = (state_q == ST_RELEASE) || (state_q == ST_RUN);

    // Two-flop synchronizer bringing the asynchronous PLL lock into clk
    always_ff @(posedge clk) begin
        if (rst) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
        end else begin
            sync1_q <= pll_lock;
            sync2_q <= sync1_q;
        end
    end

    // Next-state logic: lock loss after release outranks a soft restart
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        lock_lost_d = 1'b0;
        lost_cnt_d  = lost_cnt_q;
        if (released && !lock_s) begin
            state_d     = ST_WAIT;
            cnt_d       = '0;
            lock_lost_d = 1'b1;
            if (lost_cnt_q != 8'hFF) begin
                lost_cnt_d = lost_cnt_q + 8'd1;
            end
        end else if (soft_rst_req) begin
            state_d = ST_WAIT;
            cnt_d   = '0;
        end else begin
            case (state_q)
                ST_WAIT: begin
                    cnt_d = '0;
                    if (lock_s) begin
                        state_d = ST_STABILIZE;
                    end
                end
                ST_STABILIZE: begin
                    if (!lock_s) begin
                        state_d = ST_WAIT;
                        cnt_d   = '0;
                    end else if (cnt_q == STABLE_LAST) begin
                        state_d = ST_RELEASE;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
                ST_RELEASE: begin
                    if (cnt_q == HOLD_LAST) begin
                        state_d = ST_RUN;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
                default: begin
                    cnt_d = '0;
                end
            endcase
        end
        rst_out_d = !((state_d == ST_RELEASE) || (state_d == ST_RUN));
        ready_d   = (state_d == ST_RUN);
    end

    // State, counter and registered outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_WAIT;
            cnt_q       <= '0;
            rst_out_q   <= 1'b1;
            rst_n_out_q <= 1'b0;
            ready_q     <= 1'b0;
            lock_lost_q <= 1'b0;
            lost_cnt_q  <= 8'd0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            rst_out_q   <= rst_out_d;
            rst_n_out_q <= !rst_out_d;
            ready_q     <= ready_d;
            lock_lost_q <= lock_lost_d;
            lost_cnt_q  <= lost_cnt_d;
        end
    end

    assign rst_out       = rst_out_q;
    assign rst_n_out     = rst_n_out_q;
    assign ready         = ready_q;
    assign lock_lost     = lock_lost_q;
    assign lock_lost_cnt = lost_cnt_q;

endmodule

// File: doc/pll_reset_sequencer.md
PLL_RESET_SEQUENCER -- requirements
Module: pll_reset_sequencer

Interface
REQ-001 Parameter STABLE_CYCLES, default 1024, meaning consecutive synchronized-lock cycles required before rst_out releases; legal range >= 1.
REQ-002 Parameter HOLD_CYCLES, default 16, meaning cycles between rst_out release and ready assertion; legal range >= 1.
REQ-003 Ports SHALL be, one per line, as follows:
 clk  input  1  PLL output clock (54 MHz); sole clock.
 rst  input  1  synchronous, active-high reset.
 pll_lock  input  1  PLL lock, asynchronous to clk.
 soft_rst_req  input  1  clk-domain pulse; restarts the sequence.
 rst_out  output  1  active-high reset to downstream logic.
 rst_n_out  output  1  always the inverse of rst_out.
 ready  output  1  downstream logic released and settled.
 lock_lost  output  1  one-cycle pulse on lock loss after release.
 lock_lost_cnt  output  8  saturating count of lock-loss events.
REQ-004 All outputs SHALL be registered; no combinational input-to-output path.

Function
REQ-005 pll_lock SHALL pass through a 2-flop synchronizer; lock_s is the second flop's output.
REQ-006 FSM states SHALL be WAIT, STABILIZE, RELEASE and RUN.
REQ-007 WAIT: rst_out=1, ready=0. On lock_s=1, go to STABILIZE with cnt=0.
REQ-008 STABILIZE: rst_out=1. cnt increments each cycle that lock_s=1.
REQ-009 STABILIZE, lock_s=0: return to WAIT; lock_lost is not pulsed and lock_lost_cnt is unchanged.
REQ-010 STABILIZE, lock_s=1 and cnt==STABLE_CYCLES-1: go to RELEASE with cnt=0, and clear rst_out on the same edge.
REQ-011 rst_out SHALL fall at clock edge E0+2+STABLE_CYCLES, where E0 is the first edge that samples pll_lock=1, provided pll_lock stays high throughout.
REQ-012 RELEASE: rst_out=0, ready=0, cnt increments each cycle. At cnt==HOLD_CYCLES-1, go to RUN and set ready=1 on the same edge.
REQ-013 ready SHALL therefore rise HOLD_CYCLES edges after rst_out falls.
REQ-014 RUN: rst_out=0, ready=1; the block stays in RUN while lock_s=1.
REQ-015 RELEASE or RUN with lock_s=0: next edge SHALL enter WAIT with rst_out=1, ready=0 and lock_lost=1 for exactly one cycle.
REQ-016 On the REQ-015 event, lock_lost_cnt SHALL increment, saturating at 255 (stays 255 with no wrap).
REQ-017 soft_rst_req=1 in any state: next edge SHALL enter WAIT with rst_out=1, ready=0 and cnt=0, with no lock_lost pulse and no count change.
REQ-018 Simultaneous soft_rst_req=1 and lock loss in RELEASE or RUN: lock loss takes priority, so lock_lost pulses and the count increments.
REQ-019 Counter width SHALL be $clog2(max(STABLE_CYCLES,HOLD_CYCLES)+1). The counter never wraps, because every terminal compare exits the state.
REQ-020 A lock_s low glitch shorter than one clk period is not guaranteed to be detected; no filtering beyond the synchronizer is performed.

Reset
REQ-021 With rst=1 at an edge, the block SHALL set state=WAIT, cnt=0, both synchronizer flops=0, rst_out=1, rst_n_out=0, ready=0, lock_lost=0 and lock_lost_cnt=0.
REQ-022 rst SHALL take priority over all other inputs. rst asserted mid-sequence (in STABILIZE, RELEASE or RUN) SHALL abort it with no lock_lost pulse.
REQ-023 After rst deasserts, the sequence restarts from WAIT; synchronizer latency (REQ-011) applies afresh.

Verification (STABLE_CYCLES=8, HOLD_CYCLES=4)
REQ-024 Reset then pll_lock=1 from edge E0 -> rst_out falls at E0+10, ready rises at E0+14, and rst_n_out is always the inverse of rst_out.
REQ-025 pll_lock low for 3 cycles while in STABILIZE -> return to WAIT, rst_out stays 1, lock_lost=0, and a full 8-cycle count restarts after lock returns.
REQ-026 pll_lock drops in RUN -> lock_lost is high for 1 cycle, lock_lost_cnt goes 0->1, rst_out=1 and ready=0 on the next edges.
REQ-027 300 lock-loss events, re-locking each time -> lock_lost_cnt reads 255 and stays at 255.
REQ-028 soft_rst_req pulse in RUN -> WAIT with rst_out=1 and no lock_lost pulse; with pll_lock still 1, rst_out falls 9 edges after the pulse edge (1 to WAIT, 8 in STABILIZE).
REQ-029 soft_rst_req together with a lock drop in RUN -> lock_lost pulses and the count increments; rst asserted in RELEASE -> all outputs return to reset values on the next edge.
